// File: rtl/spi_slave_bit_sequencer_if.sv
// ---------------------------------------------------------------------------
// spi_slave_bit_sequencer_if
// Groups the frame-control inputs and the sequencing outputs of the SPI slave
// bit sequencer into one bundle.
//   csN_i        chip select, low = frame active
//   bitStrobe_i  one-cycle pulse per sampled SPI bit
//   frameLen_i   bits per word (sampled at frame start)
//   burstEn_i    1 = many words per frame, 0 = one word (sampled at frame start)
//   bitIdx_o     index of next expected bit
//   lastBit_o    next strobe completes the word
//   wordDone_o   one-cycle pulse, word completed
//   wordCount_o  words completed in current/last frame (saturating)
//   abort_o      one-cycle pulse, frame ended mid-word
//   busy_o       sequencer is in ACTIVE
// Modport master drives the frame inputs, modport slave is the sequencer.
// ---------------------------------------------------------------------------
interface spi_slave_bit_sequencer_if #(
  parameter int MAX_BITS = 16,
  parameter int WCW      = 8
);
  localparam int CW = $clog2(MAX_BITS + 1);

  logic           csN_i;
  logic           bitStrobe_i;
  logic [CW-1:0]  frameLen_i;
  logic           burstEn_i;
  logic [CW-1:0]  bitIdx_o;
  logic           lastBit_o;
  logic           wordDone_o;
  logic [WCW-1:0] wordCount_o;
  logic           abort_o;
  logic           busy_o;

  modport master (
    output csN_i, bitStrobe_i, frameLen_i, burstEn_i,
    input  bitIdx_o, lastBit_o, wordDone_o, wordCount_o, abort_o, busy_o
  );

  modport slave (
    input  csN_i, bitStrobe_i, frameLen_i, burstEn_i,
    output bitIdx_o, lastBit_o, wordDone_o, wordCount_o, abort_o, busy_o
  );
endinterface

// File: rtl/spi_slave_bit_sequencer.sv
// ---------------------------------------------------------------------------
// spi_slave_bit_sequencer
// Counts sampled SPI bits into words of a per-frame length, reports word
// completion, counts words per frame (saturating) and flags frames that end
// mid-word.
//   clk_c     single clock, all state changes on its rising edge
//   reset_rn  asynchronous active-low reset
//   bus       spi_slave_bit_sequencer_if.slave (frame inputs / status outputs)
// ---------------------------------------------------------------------------
module spi_slave_bit_sequencer #(
  parameter int MAX_BITS = 16,
  parameter int WCW      = 8
) (
  input logic                     clk_c,
  input logic                     reset_rn,
  spi_slave_bit_sequencer_if.slave bus
);
  localparam int CW = $clog2(MAX_BITS + 1);
  localparam logic [CW-1:0]  MAX_LEN = CW'(MAX_BITS);
  localparam logic [WCW-1:0] WC_MAX  = '1;

  typedef enum logic [1:0] {IDLE, ACTIVE, HOLD} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  len_q, len_d;
  logic [CW-1:0]  bit_idx_q, bit_idx_d;
  logic           burst_q, burst_d;
  logic [WCW-1:0] word_cnt_q, word_cnt_d;
  logic           word_done_q, word_done_d;
  logic           abort_q, abort_d;
  logic [CW-1:0]  last_idx;

  assign last_idx = len_q - CW'(1);

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    bit_idx_d   = bit_idx_q;
    burst_d     = burst_q;
    word_cnt_d  = word_cnt_q;
    word_done_d = 1'b0;
    abort_d     = 1'b0;
    case (state_q)
      IDLE: begin
        // Frame start; a strobe arriving in this same cycle is not counted.
        if (!bus.csN_i) begin
          state_d    = ACTIVE;
          len_d      = (bus.frameLen_i == '0 || bus.frameLen_i > MAX_LEN)
                       ? MAX_LEN : bus.frameLen_i;
          burst_d    = bus.burstEn_i;
          bit_idx_d  = '0;
          word_cnt_d = '0;
        end
      end
      ACTIVE: begin
        // Chip-select release wins over a coincident strobe.
        if (bus.csN_i) begin
          state_d   = IDLE;
          abort_d   = (bit_idx_q != '0);
          bit_idx_d = '0;
        end else if (bus.bitStrobe_i) begin
          if (bit_idx_q == last_idx) begin
            bit_idx_d   = '0;
            word_done_d = 1'b1;
            if (word_cnt_q != WC_MAX) word_cnt_d = word_cnt_q + WCW'(1);
            if (!burst_q) state_d = HOLD;
          end else begin
            bit_idx_d = bit_idx_q + CW'(1);
          end
        end
      end
      HOLD: begin
        bit_idx_d = '0;
        if (bus.csN_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_c or negedge reset_rn) begin
    if (!reset_rn) begin
      state_q     <= IDLE;
      len_q       <= MAX_LEN;
      bit_idx_q   <= '0;
      burst_q     <= 1'b0;
      word_cnt_q  <= '0;
      word_done_q <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      bit_idx_q   <= bit_idx_d;
      burst_q     <= burst_d;
      word_cnt_q  <= word_cnt_d;
      word_done_q <= word_done_d;
      abort_q     <= abort_d;
    end
  end

  assign bus.bitIdx_o    = bit_idx_q;
  assign bus.wordCount_o = word_cnt_q;
  assign bus.wordDone_o  = word_done_q;
  assign bus.abort_o     = abort_q;
  assign bus.busy_o      = (state_q == ACTIVE);
  assign bus.lastBit_o   = (state_q == ACTIVE) && (bit_idx_q == last_idx);
endmodule

// File: tb/tb_spi_slave_bit_sequencer.sv
// ---------------------------------------------------------------------------
// tb_spi_slave_bit_sequencer
// Directed frames plus randomized traffic against a frame-level reference
// model (bits received in the current word, words in the frame, whether the
// frame is open and whether it has parked after a single word).
// ---------------------------------------------------------------------------
module tb_spi_slave_bit_sequencer;
  localparam int MAX_BITS = 16;
  localparam int WCW      = 2;
  localparam int CW       = $clog2(MAX_BITS + 1);
  localparam int WC_SAT   = (1 << WCW) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  spi_slave_bit_sequencer_if #(.MAX_BITS(MAX_BITS), .WCW(WCW)) bus();

  spi_slave_bit_sequencer #(.MAX_BITS(MAX_BITS), .WCW(WCW)) dut (
    .clk_c   (clk),
    .reset_rn(rst_n),
    .bus     (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model of the frame
  bit m_open;      // chip select seen low, frame in progress
  bit m_parked;    // single-word frame has finished its word
  bit m_burst;
  int m_len;       // effective word length
  int m_got;       // bits received in the current word
  int m_words;     // words completed in this frame (saturating)
  bit m_done, m_abort;
  int done_seen, abort_seen;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_open = 0; m_parked = 0; m_burst = 0; m_len = MAX_BITS;
    m_got = 0; m_words = 0; m_done = 0; m_abort = 0;
  endtask

  task automatic model_edge(input bit cs, input bit strobe, input int fl, input bit be);
    m_done = 0; m_abort = 0;
    if (!m_open) begin
      if (!cs) begin
        m_open = 1; m_parked = 0; m_burst = be;
        m_len = (fl == 0 || fl > MAX_BITS) ? MAX_BITS : fl;
        m_got = 0; m_words = 0;
      end
    end else if (cs) begin
      m_abort = !m_parked && (m_got != 0);
      m_open = 0; m_parked = 0; m_got = 0;
    end else if (strobe && !m_parked) begin
      m_got++;
      if (m_got == m_len) begin
        m_got = 0;
        m_done = 1;
        m_words = (m_words < WC_SAT) ? m_words + 1 : WC_SAT;
        if (!m_burst) m_parked = 1;
      end
    end
  endtask

  task automatic compare_all(input string ph);
    bit eb;
    eb = m_open && !m_parked;
    check_eq({ph, ".busy"},      32'(bus.busy_o),      32'(eb));
    check_eq({ph, ".lastBit"},   32'(bus.lastBit_o),   32'(eb && (m_got == m_len - 1)));
    check_eq({ph, ".bitIdx"},    32'(bus.bitIdx_o),    32'(m_got));
    check_eq({ph, ".wordCount"}, 32'(bus.wordCount_o), 32'(m_words));
    check_eq({ph, ".wordDone"},  32'(bus.wordDone_o),  32'(m_done));
    check_eq({ph, ".abort"},     32'(bus.abort_o),     32'(m_abort));
  endtask

  // Drive one cycle of inputs, let the edge happen, then check everything.
  task automatic step(input string ph, input bit cs, input bit strobe);
    bus.csN_i = cs;
    bus.bitStrobe_i = strobe;
    @(posedge clk);
    #1;
    if (!rst_n) model_reset();
    else model_edge(cs, strobe, int'(bus.frameLen_i), bus.burstEn_i);
    compare_all(ph);
    done_seen  += int'(bus.wordDone_o);
    abort_seen += int'(bus.abort_o);
  endtask

  task automatic start_frame(input string ph, input int fl, input bit be);
    bus.frameLen_i = CW'(fl);
    bus.burstEn_i  = be;
    done_seen = 0; abort_seen = 0;
    step(ph, 1'b0, 1'b1);   // strobe in the start cycle must be ignored
  endtask

  initial begin
    bus.csN_i = 1'b1; bus.bitStrobe_i = 1'b0; bus.frameLen_i = '0; bus.burstEn_i = 1'b0;
    model_reset();
    #1 rst_n = 1'b0;
    #1 compare_all("reset");
    step("reset", 1'b1, 1'b0);
    step("reset", 1'b0, 1'b1);
    rst_n = 1'b1;
    step("idle", 1'b1, 1'b0);

    // Single word, then parked
    start_frame("single", 8, 1'b0);
    for (int i = 0; i < 8; i++) begin
      check_eq("single.idx_before", 32'(bus.bitIdx_o), 32'(i));
      step("single", 1'b0, 1'b1);
    end
    for (int i = 0; i < 3; i++) step("single_hold", 1'b0, 1'b1);
    check_eq("single.done_pulses", 32'(done_seen), 32'd1);
    check_eq("single.count", 32'(bus.wordCount_o), 32'd1);
    step("single_end", 1'b1, 1'b0);
    check_eq("single.no_abort", 32'(abort_seen), 32'd0);
    step("idle", 1'b1, 1'b0);
    check_eq("idle.count_held", 32'(bus.wordCount_o), 32'd1);

    // Burst of three 4-bit words
    start_frame("burst", 4, 1'b1);
    for (int i = 0; i < 12; i++) step("burst", 1'b0, 1'b1);
    step("burst", 1'b0, 1'b0);
    check_eq("burst.done_pulses", 32'(done_seen), 32'd3);
    check_eq("burst.count", 32'(bus.wordCount_o), 32'd3);
    step("burst_end", 1'b1, 1'b0);
    check_eq("burst.no_abort", 32'(abort_seen), 32'd0);

    // Abort mid-word with a coincident strobe
    start_frame("abort", 8, 1'b0);
    for (int i = 0; i < 5; i++) step("abort", 1'b0, 1'b1);
    step("abort_end", 1'b1, 1'b1);
    step("abort_end", 1'b1, 1'b0);
    check_eq("abort.pulses", 32'(abort_seen), 32'd1);
    check_eq("abort.count", 32'(bus.wordCount_o), 32'd0);
    check_eq("abort.idx", 32'(bus.bitIdx_o), 32'd0);

    // Strobe on the last bit coincident with CS rise is discarded
    start_frame("prio", 2, 1'b0);
    step("prio", 1'b0, 1'b1);
    step("prio_end", 1'b1, 1'b1);
    check_eq("prio.done_pulses", 32'(done_seen), 32'd0);
    check_eq("prio.abort_pulses", 32'(abort_seen), 32'd1);

    // Length 0 and out-of-range lengths clamp to MAX_BITS
    for (int k = 0; k < 2; k++) begin
      start_frame("clamp", (k == 0) ? 0 : MAX_BITS + 3, 1'b0);
      for (int i = 0; i < MAX_BITS - 1; i++) step("clamp", 1'b0, 1'b1);
      check_eq("clamp.no_early_done", 32'(done_seen), 32'd0);
      step("clamp", 1'b0, 1'b1);
      check_eq("clamp.done_pulses", 32'(done_seen), 32'd1);
      step("clamp_end", 1'b1, 1'b0);
    end

    // Length 1 in burst: every strobe is a word, counter saturates
    start_frame("len1", 1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check_eq("len1.lastBit", 32'(bus.lastBit_o), 32'd1);
      step("len1", 1'b0, 1'b1);
    end
    check_eq("len1.done_pulses", 32'(done_seen), 32'd5);
    check_eq("len1.saturated", 32'(bus.wordCount_o), 32'(WC_SAT));
    step("len1_end", 1'b1, 1'b0);

    // Asynchronous reset between edges, mid-word
    start_frame("areset", 8, 1'b1);
    for (int i = 0; i < 3; i++) step("areset", 1'b0, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("areset_now");
    step("areset_hold", 1'b0, 1'b1);
    rst_n = 1'b1;
    done_seen = 0; abort_seen = 0;
    step("areset_start", 1'b0, 1'b0);
    check_eq("areset.active_first_edge", 32'(bus.busy_o), 32'd1);
    step("areset_end", 1'b1, 1'b0);
    check_eq("areset.no_pulses", 32'(done_seen + abort_seen), 32'd0);

    // Randomized traffic; frame inputs change freely and only matter at start
    begin
      bit cs;
      cs = 1'b1;
      for (int n = 0; n < 4000; n++) begin
        if ($urandom_range(0, 99) < 4) cs = ~cs;
        if ($urandom_range(0, 1) == 0) bus.frameLen_i = CW'($urandom_range(1, 4));
        else bus.frameLen_i = CW'($urandom_range(0, MAX_BITS + 3));
        bus.burstEn_i = 1'($urandom_range(0, 1));
        step("random", cs, ($urandom_range(0, 99) < 50));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
